reg_scoreboard: RTL and testbench

- Register-file reservation controller sitting between the ID stage and the register file.
- Tracks in-flight writebacks per architectural register with a small pending counter.
- Raises a hazard to ID when an instruction reads or overwrites a register with a pending write.
- Clears reservations as the WB stage retires results; supports a global flush.

---
 rtl/reg_scoreboard_pkg.sv | 8 +
 rtl/reg_scoreboard_sb_counter.sv | 38 +++
 rtl/reg_scoreboard.sv | 78 +++++++
 tb/tb_reg_scoreboard.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: shared sizing for the register scoreboard.
// W_RN matches the ISA register-number width (W_RD/W_RS).
// N_REG is derived from W_RN. W_CNT sets the maximum number of outstanding writes per register.
package reg_scoreboard_pkg;
    localparam int SB_W_RN   = 3;
    localparam int SB_N_REG  = 1 << SB_W_RN;
    localparam int SB_W_CNT  = 2;
endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// sb_counter: saturating up/down pending-write counter for one register.
// Ports:
//   clk, rst        rising-edge clock and async active-low reset
//   inc_i, dec_i    reserve / retire
//   clr_i           flush, wins over inc/dec
//   cnt_o           current count
//   zero_o, full_o  count flags
module sb_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         dec_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o,
    output logic         full_o
);
    logic [W-1:0] cnt_q, cnt_d;
    logic         up, dn;

    // Retiring at zero has no effect. An inc paired with it therefore still counts.
    always_comb begin
        up    = inc_i & ~(dec_i & ~zero_o) & ~full_o;
        dn    = dec_i & ~zero_o & ~inc_i;
        cnt_d = clr_i ? '0 : up ? cnt_q + W'(1) : dn ? cnt_q - W'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);
    assign full_o = &cnt_q;
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write tracking and hazard detection for ID.
// Ports:
//   clk, rst                                   clock and async active-low reset
//   issue_v_i/rd/rs/use_rs/use_rd/wb/go        ID instruction description
//   hazard_o                                   combinational stall request
//   reserve_o                                  reservation taken this cycle
//   wb_v_i, wb_num_i                           WB retirement
//   flush_i                                    clear all reservations
//   busy_o                                     any reservation outstanding
//   err_o                                      sticky retire-without-reservation flag
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int W_RN  = SB_W_RN,
    parameter int N_REG = SB_N_REG,
    parameter int W_CNT = SB_W_CNT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_v_i,
    input  logic [W_RN-1:0] issue_rd_i,
    input  logic [W_RN-1:0] issue_rs_i,
    input  logic            issue_use_rs_i,
    input  logic            issue_use_rd_i,
    input  logic            issue_wb_i,
    input  logic            issue_go_i,
    output logic            hazard_o,
    output logic            reserve_o,
    input  logic            wb_v_i,
    input  logic [W_RN-1:0] wb_num_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            err_o
);
    logic [W_CNT-1:0] cnt [N_REG];
    logic [N_REG-1:0] zero, full, inc, dec;
    logic             wb_rd, wb_rs, raw_rd, raw_rs, ovf;
    logic             err_q, err_d;

    genvar i;
    generate
        for (i = 0; i < N_REG; i++) begin : g_cnt
            assign inc[i] = reserve_o && (issue_rd_i == W_RN'(i));
            assign dec[i] = wb_v_i && (wb_num_i == W_RN'(i));
            sb_counter #(.W(W_CNT)) u_cnt (
                .clk    (clk),
                .rst    (rst),
                .inc_i  (inc[i]),
                .dec_i  (dec[i]),
                .clr_i  (flush_i),
                .cnt_o  (cnt[i]),
                .zero_o (zero[i]),
                .full_o (full[i])
            );
        end
    endgenerate

    // A retire of the last pending write is forwarded by the register file, so it is not a RAW.
    // A retire also frees a slot in a full counter in the same cycle.
    always_comb begin
        wb_rd     = wb_v_i && (wb_num_i == issue_rd_i);
        wb_rs     = wb_v_i && (wb_num_i == issue_rs_i);
        raw_rd    = issue_use_rd_i & ~zero[issue_rd_i] & ~(wb_rd & (cnt[issue_rd_i] == W_CNT'(1)));
        raw_rs    = issue_use_rs_i & ~zero[issue_rs_i] & ~(wb_rs & (cnt[issue_rs_i] == W_CNT'(1)));
        ovf       = issue_wb_i & full[issue_rd_i] & ~wb_rd;
        hazard_o  = issue_v_i & (raw_rd | raw_rs | ovf);
        reserve_o = issue_v_i & issue_go_i & issue_wb_i & ~hazard_o;
        err_d     = err_q | (wb_v_i & zero[wb_num_i] & ~inc[wb_num_i]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_d;
    end

    assign busy_o = ~&zero;
    assign err_o  = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed vector table plus async-reset sequence for reg_scoreboard.
module tb_reg_scoreboard;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       issue_v, issue_use_rs, issue_use_rd, issue_wb, issue_go;
    logic [2:0] issue_rd, issue_rs, wb_num;
    logic       wb_v, flush;
    logic       hazard, reserve, busy, err;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        logic       v;
        logic [2:0] rd;
        logic [2:0] rs;
        logic       urs;
        logic       urd;
        logic       wb;
        logic       go;
        logic       wbv;
        logic [2:0] wbn;
        logic       fl;
        logic       hz;
        logic       res;
        logic       busy;
        logic       err;
    } vec_t;

    vec_t tv[$];

    reg_scoreboard dut (
        .clk            (clk),
        .rst            (rst),
        .issue_v_i      (issue_v),
        .issue_rd_i     (issue_rd),
        .issue_rs_i     (issue_rs),
        .issue_use_rs_i (issue_use_rs),
        .issue_use_rd_i (issue_use_rd),
        .issue_wb_i     (issue_wb),
        .issue_go_i     (issue_go),
        .hazard_o       (hazard),
        .reserve_o      (reserve),
        .wb_v_i         (wb_v),
        .wb_num_i       (wb_num),
        .flush_i        (flush),
        .busy_o         (busy),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(input logic v, input logic [2:0] rd, input logic [2:0] rs,
                                input logic urs, input logic urd, input logic wb, input logic go,
                                input logic wbv, input logic [2:0] wbn, input logic fl,
                                input logic hz, input logic res, input logic bsy, input logic er);
        vec_t t;
        t.v = v; t.rd = rd; t.rs = rs; t.urs = urs; t.urd = urd; t.wb = wb; t.go = go;
        t.wbv = wbv; t.wbn = wbn; t.fl = fl; t.hz = hz; t.res = res; t.busy = bsy; t.err = er;
        return t;
    endfunction

    task automatic check(input string name, input int idx, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        issue_v = t.v; issue_rd = t.rd; issue_rs = t.rs; issue_use_rs = t.urs;
        issue_use_rd = t.urd; issue_wb = t.wb; issue_go = t.go;
        wb_v = t.wbv; wb_num = t.wbn; flush = t.fl;
    endtask

    initial begin
        drive(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
        // A: reserve r3, RAW on rs, bypass on last retire
        tv.push_back(mk(1,3,0,0,0,1,1,0,0,0, 0,1,1,0));
        tv.push_back(mk(1,0,3,1,0,0,1,0,0,0, 1,0,1,0));
        tv.push_back(mk(1,0,3,1,0,0,1,1,3,0, 0,0,0,0));
        tv.push_back(mk(1,0,3,1,0,0,1,0,0,0, 0,0,0,0));
        // B: fill r5, full hazard, full+retire, RAW on rd while draining
        tv.push_back(mk(1,5,0,0,0,1,1,0,0,0, 0,1,1,0));
        tv.push_back(mk(1,5,0,0,0,1,1,0,0,0, 0,1,1,0));
        tv.push_back(mk(1,5,0,0,0,1,1,0,0,0, 0,1,1,0));
        tv.push_back(mk(1,5,0,0,0,1,1,0,0,0, 1,0,1,0));
        tv.push_back(mk(1,5,0,0,0,1,1,1,5,0, 0,1,1,0));
        tv.push_back(mk(1,5,0,0,0,1,1,0,0,0, 1,0,1,0));
        tv.push_back(mk(1,5,0,0,1,0,1,1,5,0, 1,0,1,0));
        tv.push_back(mk(1,5,0,0,1,0,1,1,5,0, 1,0,1,0));
        tv.push_back(mk(1,5,0,0,1,0,1,1,5,0, 0,0,0,0));
        // C: r2 simultaneous reserve and retire, idle issue ignored
        tv.push_back(mk(1,2,0,0,0,1,1,0,0,0, 0,1,1,0));
        tv.push_back(mk(1,2,0,0,0,1,1,1,2,0, 0,1,1,0));
        tv.push_back(mk(0,0,2,1,0,0,1,0,0,0, 0,0,1,0));
        tv.push_back(mk(1,0,2,1,0,0,1,0,0,0, 1,0,1,0));
        tv.push_back(mk(1,0,2,1,0,0,1,1,2,0, 0,0,0,0));
        tv.push_back(mk(1,0,2,1,0,0,1,0,0,0, 0,0,0,0));
        // retire at zero masked by same-cycle reservation: no error
        tv.push_back(mk(1,0,0,0,0,1,1,1,0,0, 0,1,1,0));
        tv.push_back(mk(0,0,0,0,0,0,0,1,0,0, 0,0,0,0));
        // D: stalled issue, then flush with a dropped reservation
        tv.push_back(mk(1,1,0,0,0,1,0,0,0,0, 0,0,0,0));
        tv.push_back(mk(1,0,1,1,0,0,1,0,0,0, 0,0,0,0));
        tv.push_back(mk(1,1,0,0,0,1,1,0,0,0, 0,1,1,0));
        tv.push_back(mk(1,1,0,0,0,1,1,0,0,0, 0,1,1,0));
        tv.push_back(mk(1,4,0,0,0,1,1,0,0,0, 0,1,1,0));
        tv.push_back(mk(1,6,0,0,0,1,1,0,0,1, 0,1,0,0));
        tv.push_back(mk(1,1,6,1,1,0,1,0,0,0, 0,0,0,0));
        tv.push_back(mk(1,4,0,0,1,0,1,0,0,0, 0,0,0,0));
        // E: underflow sets sticky error which survives flush
        tv.push_back(mk(0,0,0,0,0,0,0,1,6,0, 0,0,0,1));
        tv.push_back(mk(1,0,6,1,0,0,1,0,0,0, 0,0,0,1));
        tv.push_back(mk(0,0,0,0,0,0,0,0,0,1, 0,0,0,1));

        #3;
        check("rst_busy", -1, busy, 1'b0);
        check("rst_err", -1, err, 1'b0);
        check("rst_hazard", -1, hazard, 1'b0);
        check("rst_reserve", -1, reserve, 1'b0);
        #4 rst = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < tv.size(); k++) begin
            drive(tv[k]);
            #1;
            check("hazard", k, hazard, tv[k].hz);
            check("reserve", k, reserve, tv[k].res);
            @(posedge clk);
            #1;
            check("busy", k, busy, tv[k].busy);
            check("err", k, err, tv[k].err);
        end

        // async reset mid-cycle clears counts and sticky error at once
        drive(mk(1,7,0,0,0,1,1,0,0,0, 0,0,0,0));
        @(posedge clk);
        #1;
        drive(mk(1,0,7,1,0,0,1,0,0,0, 0,0,0,0));
        #1;
        check("pre_rst_hazard", 100, hazard, 1'b1);
        check("pre_rst_busy", 100, busy, 1'b1);
        check("pre_rst_err", 100, err, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("async_hazard", 101, hazard, 1'b0);
        check("async_busy", 101, busy, 1'b0);
        check("async_err", 101, err, 1'b0);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_hazard", 102, hazard, 1'b0);
        check("post_rst_busy", 102, busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
